// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer
//   Drives one strided vector load or store into the six-bank unified memory.
//   Each beat addresses every bank at the same address. Lane i maps to bank i.
//   Loads stream out over rvalid/rready. Stores are taken over wvalid/wready.
//
// Ports
//   clk, reset                       clock, async active-high reset
//   req_valid/req_ready              request handshake
//   req_store                        1 = store, 0 = load
//   req_base/req_stride              beat-0 address and per-beat increment
//   req_len                          beats minus one
//   req_mask                         lane enables
//   wvalid/wready/wdata              store data stream, byte i -> bank i
//   rvalid/rready/rdata              load data stream, byte i <- bank i
//   busy                             transaction running or load beat pending
//   mem_we/mem_a/mem_wd/mem_rd       memory port (combinational read)
//
// state | meaning
// IDLE  | waiting for a request; drains a pending load beat
// LOAD  | issuing read beats, one per free output slot
// STORE | issuing write beats, one per wvalid cycle
module vec_mem_sequencer #(
  parameter int WIDTH = 16,
  parameter int LANES = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_store,
  input  logic [WIDTH-1:0]         req_base,
  input  logic [WIDTH-1:0]         req_stride,
  input  logic [3:0]               req_len,
  input  logic [LANES-1:0]         req_mask,
  input  logic                     wvalid,
  output logic                     wready,
  input  logic [8*LANES-1:0]       wdata,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [8*LANES-1:0]       rdata,
  output logic                     busy,
  output logic [LANES-1:0]         mem_we,
  output logic [LANES*WIDTH-1:0]   mem_a,
  output logic [LANES*WIDTH-1:0]   mem_wd,
  input  logic [8*LANES-1:0]       mem_rd
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   addr_q, stride_q;
  logic [3:0]         beat_q, len_q;
  logic [LANES-1:0]   mask_q;
  logic [8*LANES-1:0] rdata_q, rd_masked;
  logic               rvalid_q;
  logic               beat_done;
  logic               last_beat;

  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign busy      = (state != IDLE) || rvalid_q;
  assign last_beat = (beat_q == len_q);

  always_comb begin
    rd_masked = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mask_q[i]) rd_masked[8*i +: 8] = mem_rd[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    wready     = 1'b0;
    beat_done  = 1'b0;
    mem_we     = '0;
    mem_a      = '0;
    mem_wd     = '0;
    case (state)
      IDLE: begin
        req_ready = !rvalid_q;
        if (req_valid && !rvalid_q) state_next = req_store ? STORE : LOAD;
      end
      LOAD: begin
        mem_a = {LANES{addr_q}};
        // A beat may only issue when the output slot is free or being emptied.
        beat_done = !rvalid_q || rready;
        if (beat_done && last_beat) state_next = IDLE;
      end
      STORE: begin
        mem_a  = {LANES{addr_q}};
        wready = 1'b1;
        for (int i = 0; i < LANES; i++) begin
          mem_wd[i*WIDTH +: WIDTH] = WIDTH'(wdata[8*i +: 8]);
        end
        beat_done = wvalid;
        if (wvalid) begin
          mem_we = mask_q;
          if (last_beat) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      stride_q <= '0;
      beat_q   <= '0;
      len_q    <= '0;
      mask_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (rvalid_q && rready) rvalid_q <= 1'b0;
        if (req_valid && !rvalid_q) begin
          addr_q   <= req_base;
          stride_q <= req_stride;
          len_q    <= req_len;
          mask_q   <= req_mask;
          beat_q   <= '0;
        end
      end
      if (beat_done) begin
        // Address wraps modulo 2^WIDTH by design.
        addr_q <= addr_q + stride_q;
        beat_q <= beat_q + 4'd1;
      end
      if (state == LOAD && beat_done) begin
        rdata_q  <= rd_masked;
        rvalid_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
module tb_vec_mem_sequencer;

  localparam int WIDTH = 16;
  localparam int LANES = 6;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   req_valid, req_ready, req_store;
  logic [WIDTH-1:0]       req_base, req_stride;
  logic [3:0]             req_len;
  logic [LANES-1:0]       req_mask;
  logic                   wvalid, wready;
  logic [8*LANES-1:0]     wdata;
  logic                   rvalid, rready;
  logic [8*LANES-1:0]     rdata;
  logic                   busy;
  logic [LANES-1:0]       mem_we;
  logic [LANES*WIDTH-1:0] mem_a, mem_wd;
  logic [8*LANES-1:0]     mem_rd;

  vec_mem_sequencer #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_base(req_base), .req_stride(req_stride), .req_len(req_len), .req_mask(req_mask),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .busy(busy),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Six-bank memory: bank i holds 0x10*i + addr[7:0] at addr until written.
  logic [7:0] mem [LANES][65536];
  bit         mem_inited;
  int         wr_count = 0;

  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < LANES; i++)
        for (int a = 0; a < 65536; a++)
          mem[i][a] <= 8'(i * 16) + 8'(a);
      mem_inited <= 1'b1;
    end else begin
      for (int i = 0; i < LANES; i++)
        if (mem_we[i]) mem[i][mem_a[i*WIDTH +: WIDTH]] <= mem_wd[i*WIDTH +: 8];
      if (mem_we != '0) wr_count <= wr_count + 1;
    end
  end

  always_comb begin
    mem_rd = '0;
    for (int i = 0; i < LANES; i++)
      mem_rd[8*i +: 8] = mem[i][mem_a[i*WIDTH +: WIDTH]];
  end

  int errors = 0;
  int checks = 0;
  logic [47:0] exp_q[$];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] model(input logic [15:0] base, input logic [15:0] stride,
                                        input int b, input logic [5:0] mask);
    logic [15:0] a;
    logic [47:0] r;
    a = base + 16'(b) * stride;
    r = '0;
    for (int i = 0; i < LANES; i++)
      if (mask[i]) r[8*i +: 8] = 8'(i * 16) + a[7:0];
    return r;
  endfunction

  // Scoreboard: rready only changes just after posedge, so the negedge view
  // of rvalid && rready is exactly the handshake at the coming posedge.
  always @(negedge clk) begin
    if (!reset && rvalid && rready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdata_extra: got %h required no beat", rdata);
      end else begin
        check("rdata", 96'(rdata), 96'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_req(input bit st, input logic [15:0] base, input logic [15:0] stride,
                          input logic [3:0] len, input logic [5:0] mask);
    int n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_store = st; req_base = base;
    req_stride = stride; req_len = len; req_mask = mask;
    do begin @(negedge clk); n++; end while (!req_ready && n < 50);
    check("req_accept", 96'(req_ready), 96'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(posedge clk); #1;
      rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      n++;
    end
    check("drain_left", 96'(exp_q.size()), 96'(0));
    check("drain_idle", 96'({busy, req_ready}), 96'(2'b01));
  endtask

  typedef struct {
    logic [15:0] base;
    logic [15:0] stride;
    logic [3:0]  len;
    logic [5:0]  mask;
    logic [47:0] first;
  } ld_vec_t;

  ld_vec_t tbl[5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'h0001, 16'h0001, 4'd2,  6'h3F, 48'h514131211101};
    tbl[1] = '{16'h0003, 16'h0000, 4'd0,  6'h05, 48'h000000230003};
    tbl[2] = '{16'hFFF0, 16'h0005, 4'd15, 6'h2A, 48'h400020000000};
    tbl[3] = '{16'h0020, 16'h0003, 4'd3,  6'h00, 48'h000000000000};
    tbl[4] = '{16'h0007, 16'h0100, 4'd4,  6'h3F, 48'h574737271707};

    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_base = '0; req_stride = '0;
    req_len = '0; req_mask = '0; wvalid = 1'b0; wdata = '0; rready = 1'b0;

    // Reset held with random inputs.
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      req_valid = 1'($urandom_range(0, 1)); req_store = 1'($urandom_range(0, 1));
      req_base = 16'($urandom); req_stride = 16'($urandom); req_len = 4'($urandom);
      req_mask = 6'($urandom); wvalid = 1'($urandom_range(0, 1));
      wdata = 48'({$urandom(), $urandom()}); rready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("reset_ctrl", 96'({req_ready, rvalid, wready, busy, mem_we}), 96'(10'b1000_000000));
      check("reset_bus", mem_a | mem_wd, 96'(0));
    end
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0; wvalid = 1'b0; rready = 1'b1;

    // Load, rready held high: three back-to-back beats one cycle after accept.
    exp_q.push_back(48'h514131211101);
    exp_q.push_back(48'h524232221202);
    exp_q.push_back(48'h534333231303);
    send_req(1'b0, 16'h0001, 16'h0001, 4'd2, 6'h3F);
    @(negedge clk); check("load_lat_first", 96'(rvalid), 96'(0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); check("load_stream", 96'(rvalid), 96'(1));
    end
    @(negedge clk); check("load_done", 96'({rvalid, req_ready, busy}), 96'(3'b010));

    // Load backpressure: first beat and address held while rready is low.
    rready = 1'b0;
    exp_q.push_back(48'h514131211101);
    exp_q.push_back(48'h524232221202);
    exp_q.push_back(48'h534333231303);
    send_req(1'b0, 16'h0001, 16'h0001, 4'd2, 6'h3F);
    @(negedge clk); check("bp_lat", 96'(rvalid), 96'(0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_rvalid", 96'(rvalid), 96'(1));
      check("bp_rdata", 96'(rdata), 96'(48'h514131211101));
      check("bp_addr", mem_a, {6{16'h0002}});
    end
    @(posedge clk); #1; rready = 1'b1;
    drain(1'b0);

    // Table of loads with random backpressure.
    for (int t = 0; t < 5; t++) begin
      exp_q.push_back(tbl[t].first);
      for (int b = 1; b <= int'(tbl[t].len); b++)
        exp_q.push_back(model(tbl[t].base, tbl[t].stride, b, tbl[t].mask));
      send_req(1'b0, tbl[t].base, tbl[t].stride, tbl[t].len, tbl[t].mask);
      drain(1'b1);
    end

    // Store with a two-cycle wvalid gap.
    begin
      int wr0;
      wr0 = wr_count;
      send_req(1'b1, 16'h0000, 16'h0002, 4'd1, 6'b001001);
      wvalid = 1'b1; wdata = 48'h665544332211;
      @(negedge clk);
      check("st_wready", 96'(wready), 96'(1));
      check("st_we0", 96'(mem_we), 96'(6'b001001));
      check("st_a0", mem_a, 96'(0));
      check("st_wd0", 96'({mem_wd[3*WIDTH +: WIDTH], mem_wd[0 +: WIDTH]}), 96'(32'h0044_0011));
      @(posedge clk); #1; wvalid = 1'b0;
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        check("st_gap_we", 96'(mem_we), 96'(0));
        check("st_gap_a", mem_a, {6{16'h0002}});
        @(posedge clk); #1;
      end
      wvalid = 1'b1; wdata = 48'hCCBBAA998877;
      @(negedge clk); check("st_we1", 96'(mem_we), 96'(6'b001001));
      @(posedge clk); #1; wvalid = 1'b0;
      @(negedge clk);
      check("st_done", 96'({busy, req_ready, mem_we}), 96'(8'b01_000000));
      check("st_writes", 96'(wr_count - wr0), 96'(2));
      check("st_b0a0", 96'(mem[0][0]), 96'(8'h11));
      check("st_b3a0", 96'(mem[3][0]), 96'(8'h44));
      check("st_b0a2", 96'(mem[0][2]), 96'(8'h77));
      check("st_b3a2", 96'(mem[3][2]), 96'(8'hAA));
      check("st_keep", 96'({mem[1][0], mem[5][2], mem[3][1], mem[0][1]}), 96'(32'h10523101));
    end

    // wvalid in IDLE is ignored.
    @(posedge clk); #1; wvalid = 1'b1;
    @(negedge clk); check("idle_wvalid", 96'({wready, mem_we}), 96'(0));
    @(posedge clk); #1; wvalid = 1'b0;

    // Store wrapping past 0xFFFF, aborted by reset after beat 0.
    begin
      int wr0;
      wr0 = wr_count;
      send_req(1'b1, 16'hFFFF, 16'h0001, 4'd1, 6'h3F);
      wvalid = 1'b1; wdata = 48'h010203040506;
      @(negedge clk);
      check("wrap_a0", mem_a, {6{16'hFFFF}});
      check("wrap_we0", 96'(mem_we), 96'(6'h3F));
      @(posedge clk); #1; reset = 1'b1;
      @(negedge clk);
      check("abort_bus", 96'({mem_we, busy}), 96'(0));
      check("abort_a", mem_a, 96'(0));
      @(posedge clk); #1; reset = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      check("abort_ready", 96'(req_ready), 96'(1));
      check("wrap_writes", 96'(wr_count - wr0), 96'(1));
      check("wrap_bffff", 96'({mem[0][16'hFFFF], mem[2][16'hFFFF], mem[5][16'hFFFF]}), 96'(24'h060401));
      check("wrap_b0000", 96'({mem[0][0], mem[1][0], mem[2][0], mem[4][0], mem[5][0]}), 96'(40'h1110204050));
    end

    // Load aborted by reset while a beat is pending.
    rready = 1'b0;
    send_req(1'b0, 16'h0010, 16'h0001, 4'd3, 6'h3F);
    @(negedge clk); @(negedge clk);
    check("ld_pending", 96'(rvalid), 96'(1));
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk); check("ld_abort", 96'({rvalid, busy, rdata}), 96'(0));
    @(posedge clk); #1; reset = 1'b0; rready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); check("ld_abort_quiet", 96'({rvalid, busy, req_ready}), 96'(3'b001));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vec_mem_sequencer.md
Name: vec_mem_sequencer

Overview:
- Sits directly upstream of the six-bank unified memory and drives its `we`/`a`/`wd` and consumes its `rd`.
- Accepts one strided vector load or store request per transaction.
- Sequences it beat by beat across all six banks, with lane i mapped to bank i.
- Returns load data over a valid/ready stream; takes store data over a second valid/ready stream.

Parameters:
- WIDTH, 16, per-bank address width; matches the memory's per-bank address/write-data slice width.
- LANES, 6, number of banks/lanes; fixed at 6 for the current memory.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when req_valid && req_ready at posedge.
- req_store  in  1  1 = store, 0 = load.
- req_base  in  WIDTH  address of beat 0 (same for every bank).
- req_stride  in  WIDTH  address increment per beat.
- req_len  in  4  number of beats minus 1 (1..16 beats).
- req_mask  in  6  lane enable; bit i = bank i.
- wvalid  in  1  store beat data offered.
- wready  out  1  store beat accepted when wvalid && wready.
- wdata  in  48  store bytes; byte i -> bank i.
- rvalid  out  1  load beat available.
- rready  in  1  load beat consumed when rvalid && rready.
- rdata  out  48  load bytes; byte i from bank i; masked lanes read as 0.
- busy  out  1  transaction in progress or load beat pending.
- mem_we  out  6  to memory `we`.
- mem_a  out  6*WIDTH  to memory `a`; slice i = bank i address.
- mem_wd  out  6*WIDTH  to memory `wd`; slice i = {zeros, wdata byte i}.
- mem_rd  in  48  from memory `rd` (combinational read).

Behaviour:
- FSM states: IDLE, LOAD, STORE. Registers: addr_q (WIDTH), beat_q (4), len_q, mask_q, stride_q, rdata, rvalid.
- Reset (async, immediate) sets:
  - state = IDLE; rvalid = 0; rdata = 0; addr_q = 0; beat_q = 0.
  - Outputs then: req_ready = 1, wready = 0, busy = 0, mem_we = 0, mem_a = 0, mem_wd = 0.
- req_ready = (state == IDLE) && !rvalid.
- busy = (state != IDLE) || rvalid.
- Accept in IDLE:
  - Latch base into addr_q; latch stride, len, mask.
  - beat_q = 0.
  - Go to STORE if req_store, else LOAD.
- All six mem_a slices are driven with addr_q in LOAD/STORE, and 0 in IDLE.
- addr_q += stride_q on each completed beat, modulo 2^WIDTH (wraps silently).
- LOAD:
  - A beat completes on a posedge where (!rvalid || rready).
  - On completion: rdata lane i = mem_rd byte i if mask_q[i], else 0; rvalid = 1.
  - If rvalid && !rready: hold rdata, addr_q and beat_q.
  - First rvalid appears 1 cycle after acceptance; with rready = 1, throughput is 1 beat/cycle.
  - On the beat where beat_q == len_q: go to IDLE; rvalid stays asserted until consumed.
  - In IDLE: rvalid && rready clears rvalid.
  - mem_we = 0 throughout.
- STORE:
  - wready = 1.
  - mem_we = mask_q when wvalid, else 0 (combinational).
  - mem_wd slice i = zero-extended wdata byte i.
  - Memory commits the write at the same posedge; that edge completes the beat.
  - Gaps in wvalid insert idle cycles with no write.
  - After the beat where beat_q == len_q: go to IDLE.
  - rvalid stays 0.
- mask = 0:
  - Load still produces len+1 beats, all-zero rdata.
  - Store still consumes len+1 wdata beats, with mem_we = 0.
- wvalid outside STORE is ignored (wready = 0). req_valid outside IDLE is ignored.
- Reset mid-transaction aborts immediately:
  - No further mem_we.
  - Any pending rdata is discarded.
  - Remaining beats are never issued.

Test Plan:
- Reset held, random inputs -> req_ready = 1, rvalid = 0, wready = 0, busy = 0, mem_we = 0, mem_a = 0 throughout.
- Load, rready = 1 throughout:
  - Stimulus: base 0x0001, stride 1, len 2, mask 6'h3F; memory bank i holds byte 0x10*i + addr at addr.
  - Response: rvalid on 3 consecutive cycles starting 1 cycle after accept; rdata = 0x514131211101, 0x524232221202, 0x534333231303; then req_ready = 1.
- Load backpressure:
  - Stimulus: same request, rready = 0 for 3 cycles after the first rvalid.
  - Response: rdata = 0x514131211101 stable; mem_a slices = 0x0002 held; remaining beats unchanged once rready = 1.
- Load masked:
  - Stimulus: mask 6'b000101, len 0, base 0x0003.
  - Response: single beat, rdata = 0x000000230003.
- Store:
  - Stimulus: base 0x0000, stride 2, len 1, mask 6'b001001; beats 0x665544332211 then (after a 2-cycle wvalid gap) 0xCCBBAA998877.
  - Response: mem_we = 6'b001001 only on the two wvalid cycles; bank0[0] = 0x11, bank3[0] = 0x44, bank0[2] = 0x77, bank3[2] = 0xAA; all other locations unchanged.
- Wrap and abort:
  - Stimulus: store base 0xFFFF, stride 1, len 1, mask 6'h3F; reset asserted after beat 0.
  - Response: beat 0 mem_a = 0xFFFF with write; mem_we drops to 0 in the same cycle as reset; no access to 0x0000; after reset release, req_ready = 1.
